// File: rtl/tea_block_assembler.sv
// Byte-mux sequencer: walks the 8:1 mux select, packs eight bytes into a 64-bit
// TEA block (byte 0 in the MSBs) and offers it downstream over valid/ready.
module tea_block_assembler #(
  parameter int unsigned BYTES  = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [SEL_W-1:0]        sel,
  input  logic [BYTE_W-1:0]       byte_in,
  output logic [BYTES*BYTE_W-1:0] block,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic                    busy
);

  localparam int unsigned BLK_W = BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    HOLD
  } state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   cnt, cnt_n;
  logic [BLK_W-1:0]   block_n;
  logic               valid_n;
  logic               busy_n;

  // cnt is the mux select itself, so sel comes straight off a flop
  assign sel = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      block       <= '0;
      block_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      block       <= block_n;
      block_valid <= valid_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    block_n = block;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = GATHER;
          cnt_n   = '0;
        end
      end
      GATHER: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          block_n = '0;
        end else begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (cnt == SEL_W'(i)) block_n[BLK_W-1-i*BYTE_W -: BYTE_W] = byte_in;
          end
          cnt_n = cnt + SEL_W'(1);
          if (cnt == SEL_W'(BYTES - 1)) state_n = HOLD;
        end
      end
      HOLD: begin
        // block only leaves on an accepted transfer; start chains the next one
        if (block_ready) begin
          state_n = start ? GATHER : IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    valid_n = (state_n == HOLD);
    busy_n  = (state_n != IDLE);
  end

endmodule

// File: tb/tb_tea_block_assembler.sv
// Directed + randomized bench for tea_block_assembler with a behavioural mux
// and a block-level reference model.
module tb_tea_block_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  sel;
  logic [7:0]  byte_in;
  logic [63:0] block;
  logic        block_valid;
  logic        block_ready;
  logic        busy;

  logic [7:0]  mux_in [8];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] last_blk;

  tea_block_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .sel         (sel),
    .byte_in     (byte_in),
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // upstream combinational 8:1 mux
  assign byte_in = mux_in[sel];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: block is the mux inputs concatenated, input 0 most significant
  function automatic logic [63:0] exp_block();
    logic [63:0] e = '0;
    for (int i = 0; i < 8; i++) e = (e << 8) | 64'(mux_in[i]);
    return e;
  endfunction

  task automatic set_mux_seq(input logic [7:0] base);
    for (int i = 0; i < 8; i++) mux_in[i] = base + 8'(i);
  endtask

  task automatic set_mux_rand();
    for (int i = 0; i < 8; i++) mux_in[i] = 8'($urandom_range(0, 255));
  endtask

  // from IDLE: start one block; pulse_at >= 0 raises start again mid-gather
  task automatic run_block(input int pulse_at);
    logic [63:0] e;
    e = exp_block();
    start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("gather_sel", 64'(sel), 64'(i));
      check("gather_busy", 64'(busy), 64'd1);
      check("gather_valid", 64'(block_valid), 64'd0);
      start = (i == pulse_at) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    check("hold_valid", 64'(block_valid), 64'd1);
    check("hold_block", block, e);
    check("hold_sel", 64'(sel), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    last_blk = e;
  endtask

  task automatic transfer_to_idle();
    block_ready = 1'b1;
    start = 1'b0;
    step();
    block_ready = 1'b0;
    check("xfer_valid", 64'(block_valid), 64'd0);
    check("xfer_busy", 64'(busy), 64'd0);
    check("xfer_keep", block, last_blk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; block_ready = 1'b0;
    set_mux_seq(8'h01);
    last_blk = '0;
    repeat (3) step();
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_block", block, 64'd0);
    check("rst_valid", 64'(block_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: basic gather
    run_block(-1);
    check("t1_const", block, 64'h0102030405060708);

    // 2: backpressure, mux inputs change underneath
    for (int i = 0; i < 8; i++) mux_in[i] = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      step();
      check("t2_valid", 64'(block_valid), 64'd1);
      check("t2_block", block, 64'h0102030405060708);
    end
    transfer_to_idle();

    // 3: back-to-back with start and ready held high
    set_mux_seq(8'hA0);
    start = 1'b1;
    block_ready = 1'b1;
    step();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) begin
        check("t3_sel", 64'(sel), 64'(i));
        check("t3_busy", 64'(busy), 64'd1);
        step();
      end
      check("t3_valid", 64'(block_valid), 64'd1);
      check("t3_block", block, 64'hA0A1A2A3A4A5A6A7);
      if (b == 2) start = 1'b0;
      step();
      if (b < 2) begin
        check("t3_resume_sel", 64'(sel), 64'd0);
        check("t3_resume_busy", 64'(busy), 64'd1);
      end
    end
    block_ready = 1'b0;
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_idle_valid", 64'(block_valid), 64'd0);

    // 4: abort at cnt=4
    set_mux_rand();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("t4_sel4", 64'(sel), 64'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_block", block, 64'd0);
    check("t4_sel", 64'(sel), 64'd0);
    for (int c = 0; c < 10; c++) begin
      check("t4_novalid", 64'(block_valid), 64'd0);
      step();
    end
    run_block(-1);
    transfer_to_idle();

    // 5: async reset between edges at cnt=5
    set_mux_rand();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("t5_sel5", 64'(sel), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_sel", 64'(sel), 64'd0);
    check("t5_block", block, 64'd0);
    check("t5_valid", 64'(block_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    repeat (2) step();
    check("t5_held", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();
    set_mux_rand();
    run_block(-1);
    transfer_to_idle();

    // 6: start pulses during gather and during hold without ready
    set_mux_rand();
    run_block(3);
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      step();
      check("t6_valid", 64'(block_valid), 64'd1);
      check("t6_block", block, last_blk);
      check("t6_sel", 64'(sel), 64'd0);
    end
    transfer_to_idle();

    // randomized blocks with random backpressure and idle gaps
    for (int r = 0; r < 12; r++) begin
      set_mux_rand();
      run_block($urandom_range(0, 1) == 1 ? int'($urandom_range(0, 7)) : -1);
      set_mux_rand();
      repeat ($urandom_range(0, 4)) begin
        block_ready = 1'b0;
        step();
        check("rnd_valid", 64'(block_valid), 64'd1);
        check("rnd_block", block, last_blk);
      end
      transfer_to_idle();
      repeat ($urandom_range(0, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
